tbird_lamp_monitor: RTL and testbench

- Synthesizable receive-side monitor for the six-lamp Thunderbird tail-light sequence.
- Samples the lamp vector and the left/right request inputs once per clock. Decodes the lamp vector into direction and phase.
- Flags illegal frames, illegal transitions and unrequested starts. Counts errors and completed sequences.
- Sits alongside the tail-light FSM on silicon or FPGA as an in-system checker, so lamp behaviour is checked without a vector file.

---
 rtl/tbird_lamp_monitor.sv | 156 +++++++++++++++
 tb/tb_tbird_lamp_monitor.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbird_lamp_monitor.sv
// In-system checker for the six-lamp Thunderbird tail-light sequence.
// Decodes each lamp frame, tracks the sequence and flags and counts violations.
module tbird_lamp_monitor #(
   parameter int unsigned CNT_W     = 8,
   parameter bit          CHECK_REQ = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             left,
   input  logic             right,
   input  logic [5:0]       lamps,
   output logic [1:0]       dir,
   output logic [1:0]       phase,
   output logic             seq_done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] seq_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_UNSYNC
   } state_t;

   typedef enum logic [1:0] {
      E_NONE  = 2'b00,
      E_FRAME = 2'b01,
      E_TRANS = 2'b10,
      E_UNREQ = 2'b11
   } err_code_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t    state;
   state_t    state_nxt;
   state_t    frame_state;
   logic      frame_ok;
   logic      left_q;
   logic      right_q;
   logic      err_nxt;
   logic      done_nxt;
   err_code_t code_nxt;
   logic [1:0] dir_nxt;
   logic [1:0] phase_nxt;

   function automatic logic legal_move(input state_t from, input state_t to);
      logic ok;
      case (from)
         S_IDLE:  ok = (to == S_IDLE) || (to == S_L1) || (to == S_R1);
         S_L1:    ok = (to == S_L2);
         S_L2:    ok = (to == S_L3);
         S_R1:    ok = (to == S_R2);
         S_R2:    ok = (to == S_R3);
         S_L3,
         S_R3:    ok = (to == S_IDLE);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // NOTE: every combinational output gets a default before the case so no latch is inferred.
   always_comb begin
      frame_ok    = 1'b1;
      frame_state = S_IDLE;
      case (lamps)
         6'b000000: frame_state = S_IDLE;
         6'b001000: frame_state = S_L1;
         6'b011000: frame_state = S_L2;
         6'b111000: frame_state = S_L3;
         6'b000100: frame_state = S_R1;
         6'b000110: frame_state = S_R2;
         6'b000111: frame_state = S_R3;
         default:   frame_ok    = 1'b0;
      endcase
   end

   // An illegal frame outranks every other check; a bad transition outranks the request check.
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      done_nxt  = 1'b0;
      code_nxt  = E_NONE;
      if (state == S_UNSYNC) begin
         if (frame_ok && (frame_state == S_IDLE)) begin
            state_nxt = S_IDLE;
         end
      end else if (!frame_ok) begin
         state_nxt = S_UNSYNC;
         err_nxt   = 1'b1;
         code_nxt  = E_FRAME;
      end else begin
         state_nxt = frame_state;
         if (!legal_move(state, frame_state)) begin
            err_nxt  = 1'b1;
            code_nxt = E_TRANS;
         end else if (CHECK_REQ && (state == S_IDLE) &&
                      (((frame_state == S_L1) && !left_q) ||
                       ((frame_state == S_R1) && !right_q))) begin
            err_nxt  = 1'b1;
            code_nxt = E_UNREQ;
         end else if ((state == S_L3) || (state == S_R3)) begin
            done_nxt = 1'b1;
         end
      end
   end

   always_comb begin
      dir_nxt   = 2'b00;
      phase_nxt = 2'd0;
      case (state_nxt)
         S_L1:     begin dir_nxt = 2'b01; phase_nxt = 2'd1; end
         S_L2:     begin dir_nxt = 2'b01; phase_nxt = 2'd2; end
         S_L3:     begin dir_nxt = 2'b01; phase_nxt = 2'd3; end
         S_R1:     begin dir_nxt = 2'b10; phase_nxt = 2'd1; end
         S_R2:     begin dir_nxt = 2'b10; phase_nxt = 2'd2; end
         S_R3:     begin dir_nxt = 2'b10; phase_nxt = 2'd3; end
         S_UNSYNC: begin dir_nxt = 2'b11; phase_nxt = 2'd0; end
         default:  begin dir_nxt = 2'b00; phase_nxt = 2'd0; end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         left_q    <= 1'b0;
         right_q   <= 1'b0;
         dir       <= 2'b00;
         phase     <= 2'd0;
         seq_done  <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'b00;
         err_count <= '0;
         seq_count <= '0;
      end else begin
         state    <= state_nxt;
         left_q   <= left;
         right_q  <= right;
         dir      <= dir_nxt;
         phase    <= phase_nxt;
         seq_done <= done_nxt;
         err      <= err_nxt;
         if (err_nxt) begin
            err_code <= code_nxt;
         end
         if (err_nxt && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_ONE;
         end
         if (done_nxt && (seq_count != CNT_MAX)) begin
            seq_count <= seq_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_tbird_lamp_monitor.sv
// Bench for tbird_lamp_monitor: three parameterisations driven in lock-step,
// compared every cycle against a rule-level model of the lamp sequence.
module tb_tbird_lamp_monitor;

   logic       clk;
   logic       reset;
   logic       left;
   logic       right;
   logic [5:0] lamps;

   logic [1:0] o_dir   [3];
   logic [1:0] o_phase [3];
   logic       o_done  [3];
   logic       o_err   [3];
   logic [1:0] o_code  [3];
   logic [7:0] o_errc  [3];
   logic [7:0] o_seqc  [3];
   logic [1:0] errc2;
   logic [1:0] seqc2;

   assign o_errc[2] = {6'b0, errc2};
   assign o_seqc[2] = {6'b0, seqc2};

   int n_cmp = 0;
   int n_bad = 0;

   // Per-instance configuration: request checking and counter ceiling.
   int chk  [3] = '{1, 0, 1};
   int cmax [3] = '{255, 255, 3};

   // Model: sync flag, side (0 none, 1 left, 2 right), lamps lit, registered requests.
   bit       m_sync;
   int       m_side;
   int       m_cnt;
   bit       m_lq;
   bit       m_rq;
   bit       x_done;
   bit       x_err  [3];
   int       x_code [3];
   int       x_errc [3];
   int       x_seqc [3];
   int       x_dir;
   int       x_phase;

   tbird_lamp_monitor #(.CNT_W(8), .CHECK_REQ(1'b1)) u_dut0 (
      .clk(clk), .reset(reset), .left(left), .right(right), .lamps(lamps),
      .dir(o_dir[0]), .phase(o_phase[0]), .seq_done(o_done[0]), .err(o_err[0]),
      .err_code(o_code[0]), .err_count(o_errc[0]), .seq_count(o_seqc[0]));

   tbird_lamp_monitor #(.CNT_W(8), .CHECK_REQ(1'b0)) u_dut1 (
      .clk(clk), .reset(reset), .left(left), .right(right), .lamps(lamps),
      .dir(o_dir[1]), .phase(o_phase[1]), .seq_done(o_done[1]), .err(o_err[1]),
      .err_code(o_code[1]), .err_count(o_errc[1]), .seq_count(o_seqc[1]));

   tbird_lamp_monitor #(.CNT_W(2), .CHECK_REQ(1'b1)) u_dut2 (
      .clk(clk), .reset(reset), .left(left), .right(right), .lamps(lamps),
      .dir(o_dir[2]), .phase(o_phase[2]), .seq_done(o_done[2]), .err(o_err[2]),
      .err_code(o_code[2]), .err_count(errc2), .seq_count(seqc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lamp pattern for a side and a number of lit lamps (lamps light outward from the centre).
   function automatic logic [5:0] frame_of(input int side, input int cnt);
      logic [2:0] t;
      t = (cnt == 0) ? 3'b000 : (cnt == 1) ? 3'b001 : (cnt == 2) ? 3'b011 : 3'b111;
      if (side == 1) return {t, 3'b000};
      if (side == 2) return {3'b000, t[0], t[1], t[2]};
      return 6'b000000;
   endfunction

   task automatic model_reset();
      m_sync = 1'b1;
      m_side = 0;
      m_cnt  = 0;
      m_lq   = 1'b0;
      m_rq   = 1'b0;
      x_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         x_err[i]  = 1'b0;
         x_code[i] = 0;
         x_errc[i] = 0;
         x_seqc[i] = 0;
      end
      x_dir   = 0;
      x_phase = 0;
   endtask

   task automatic model_step(input logic [5:0] f, input logic l, input logic r);
      bit legal;
      bit ok;
      bit unreq;
      int fs;
      int fc;
      int code;
      legal = (f == 6'b000000);
      fs    = 0;
      fc    = 0;
      for (int s = 1; s <= 2; s++)
         for (int c = 1; c <= 3; c++)
            if (f == frame_of(s, c)) begin
               legal = 1'b1;
               fs    = s;
               fc    = c;
            end
      x_done = 1'b0;
      code   = 0;
      unreq  = 1'b0;
      if (!m_sync) begin
         if (f == 6'b000000) begin
            m_sync = 1'b1;
            m_side = 0;
            m_cnt  = 0;
         end
      end else if (!legal) begin
         m_sync = 1'b0;
         code   = 1;
      end else begin
         if (m_cnt == 0)      ok = (fc <= 1);
         else if (m_cnt == 3) ok = (fc == 0);
         else                 ok = (fs == m_side) && (fc == m_cnt + 1);
         if (!ok) code = 2;
         else if (m_cnt == 0 && fc == 1) unreq = (fs == 1) ? !m_lq : !m_rq;
         else if (m_cnt == 3) x_done = 1'b1;
         m_side = fs;
         m_cnt  = fc;
      end
      for (int i = 0; i < 3; i++) begin
         x_err[i] = 1'b0;
         if (code != 0) begin
            x_err[i]  = 1'b1;
            x_code[i] = code;
         end else if (unreq && chk[i] != 0) begin
            x_err[i]  = 1'b1;
            x_code[i] = 3;
         end
         if (x_err[i] && x_errc[i] < cmax[i]) x_errc[i]++;
         if (x_done && x_seqc[i] < cmax[i]) x_seqc[i]++;
      end
      m_lq    = l;
      m_rq    = r;
      x_dir   = m_sync ? m_side : 3;
      x_phase = m_sync ? m_cnt : 0;
   endtask

   task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, idx, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         check("dir",       i, 32'(o_dir[i]),   32'(x_dir));
         check("phase",     i, 32'(o_phase[i]), 32'(x_phase));
         check("seq_done",  i, 32'(o_done[i]),  32'(x_done));
         check("err",       i, 32'(o_err[i]),   32'(x_err[i]));
         check("err_code",  i, 32'(o_code[i]),  32'(x_code[i]));
         check("err_count", i, 32'(o_errc[i]),  32'(x_errc[i]));
         check("seq_count", i, 32'(o_seqc[i]),  32'(x_seqc[i]));
      end
   endtask

   // Drive one frame, let one rising edge pass, then compare away from the edge.
   task automatic step(input logic [5:0] f, input logic l, input logic r);
      lamps = f;
      left  = l;
      right = r;
      @(posedge clk);
      #1;
      model_step(f, l, r);
      check_all();
      @(negedge clk);
   endtask

   localparam logic [5:0] F_IDLE = 6'b000000;
   localparam logic [5:0] F_L1   = 6'b001000;
   localparam logic [5:0] F_L2   = 6'b011000;
   localparam logic [5:0] F_L3   = 6'b111000;
   localparam logic [5:0] F_R1   = 6'b000100;
   localparam logic [5:0] F_R2   = 6'b000110;
   localparam logic [5:0] F_R3   = 6'b000111;

   initial begin
      logic [5:0] f;
      int         r;
      reset = 1'b0;
      left  = 1'b0;
      right = 1'b0;
      lamps = F_IDLE;
      model_reset();

      // Reset state, then release at 22 ns.
      #20;
      check_all();
      #2;
      reset = 1'b1;

      // Full left sequence with left requested.
      step(F_IDLE, 1'b1, 1'b0);
      step(F_L1,   1'b1, 1'b0);
      step(F_L2,   1'b1, 1'b0);
      step(F_L3,   1'b1, 1'b0);
      step(F_IDLE, 1'b0, 1'b0);
      check("seq_done_direct", 0, 32'(o_done[0]), 32'd1);
      check("seq_count_direct", 0, 32'(o_seqc[0]), 32'd1);
      check("err_count_direct", 0, 32'(o_errc[0]), 32'd0);

      // Unrequested right start: flagged only where requests are checked.
      step(F_IDLE, 1'b0, 1'b0);
      step(F_R1,   1'b0, 1'b0);
      check("unreq_err", 0, 32'(o_err[0]), 32'd1);
      check("unreq_code", 0, 32'(o_code[0]), 32'd3);
      check("unreq_dir", 0, 32'(o_dir[0]), 32'd2);
      check("unreq_ignored", 1, 32'(o_err[1]), 32'd0);
      step(F_R2,   1'b0, 1'b0);
      step(F_R3,   1'b0, 1'b0);
      step(F_IDLE, 1'b0, 1'b0);

      // Skipped phase resynchronises, then completes.
      step(F_IDLE, 1'b1, 1'b0);
      step(F_L1,   1'b1, 1'b0);
      step(F_L3,   1'b1, 1'b0);
      check("skip_code", 0, 32'(o_code[0]), 32'd2);
      check("skip_phase", 0, 32'(o_phase[0]), 32'd3);
      step(F_IDLE, 1'b0, 1'b0);
      check("skip_done", 0, 32'(o_done[0]), 32'd1);

      // Illegal frame, UNSYNC hold, recovery on IDLE.
      step(6'b101010, 1'b0, 1'b0);
      check("frame_code", 0, 32'(o_code[0]), 32'd1);
      check("frame_dir", 0, 32'(o_dir[0]), 32'd3);
      step(F_L1,   1'b0, 1'b0);
      check("unsync_hold", 0, 32'(o_err[0]), 32'd0);
      step(F_IDLE, 1'b0, 1'b0);
      check("unsync_exit", 0, 32'(o_dir[0]), 32'd0);

      // Five illegal transitions: the 2-bit counter pins at 3 while err keeps pulsing.
      for (int k = 0; k < 5; k++) begin
         step(F_L2, 1'b0, 1'b0);
         check("sat_err", 2, 32'(o_err[2]), 32'd1);
      end
      check("sat_count", 2, 32'(o_errc[2]), 32'd3);
      check("wide_count", 0, 32'(o_errc[0]), 32'd8);

      // Asynchronous reset in R2, then R3 from IDLE is an illegal transition.
      step(F_IDLE, 1'b0, 1'b1);
      step(F_IDLE, 1'b0, 1'b1);
      step(F_R1,   1'b0, 1'b1);
      step(F_R2,   1'b0, 1'b1);
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step(F_R3, 1'b0, 1'b0);
      check("post_reset_code", 0, 32'(o_code[0]), 32'd2);
      check("post_reset_dir", 0, 32'(o_dir[0]), 32'd2);

      // Randomised traffic, mostly well-formed sequences with injected faults.
      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(99));
         if (r < 8) begin
            f = 6'($urandom);
         end else if (r < 18) begin
            f = frame_of(int'($urandom_range(1, 2)), int'($urandom_range(1, 3)));
         end else if (!m_sync || m_cnt == 0 || m_cnt == 3) begin
            f = (m_sync && m_cnt == 0 && r < 70) ? frame_of(int'($urandom_range(1, 2)), 1) : F_IDLE;
         end else begin
            f = frame_of(m_side, m_cnt + 1);
         end
         step(f, 1'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
